// File: rtl/camera_frame_buffer.sv
// Multi-buffer raster frame capture: writes each frame into a rotating buffer and
// publishes it to the registered read port only once the last pixel has landed.
// dbg_state reports the FSM: 0 = IDLE, 1 = CAPTURE, 2 = COMMIT.
module camera_frame_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUFS   = 2,
  localparam int PIXELS    = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_W    = $clog2(PIXELS),
  localparam int BUF_W     = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  localparam int HC_W      = $clog2(IMG_WIDTH),
  localparam int VC_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  w_req,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [HC_W-1:0]       hcount,
  output logic [VC_W-1:0]       vcount,
  output logic                  busy,
  output logic                  frame_valid,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [HC_W-1:0]   H_LAST  = HC_W'(IMG_WIDTH - 1);
  localparam logic [VC_W-1:0]   V_LAST  = VC_W'(IMG_HEIGHT - 1);
  localparam logic [BUF_W-1:0]  B_LAST  = BUF_W'(NUM_BUFS - 1);
  localparam logic [ADDR_W:0]   PIX_LIM = (ADDR_W + 1)'(PIXELS);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       w_addr;
  logic [BUF_W-1:0]        wr_buf, rd_buf;
  logic                    wr_en;
  logic                    last_px;
  logic [DATA_WIDTH-1:0]   mem [NUM_BUFS][PIXELS];

  assign last_px   = (hcount == H_LAST) && (vcount == V_LAST);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Next state and write strobe. abort outranks the last-pixel transition,
  // and an aborted pixel is never written.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req || cont) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (din_valid) begin
          wr_en = 1'b1;
          if (last_px) state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = (w_req || cont) ? CAPTURE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Raster position; w_addr runs alongside so no multiply is needed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hcount <= '0;
      vcount <= '0;
      w_addr <= '0;
    end else if (state_q == CAPTURE) begin
      if (abort || (din_valid && last_px)) begin
        hcount <= '0;
        vcount <= '0;
        w_addr <= '0;
      end else if (din_valid) begin
        w_addr <= w_addr + ADDR_W'(1);
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= vcount + VC_W'(1);
        end else begin
          hcount <= hcount + HC_W'(1);
        end
      end
    end
  end

  // Publication: the just-filled buffer becomes readable and writing moves on.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_buf      <= '0;
      rd_buf      <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state_q == COMMIT) begin
        rd_buf      <= wr_buf;
        wr_buf      <= (wr_buf == B_LAST) ? '0 : wr_buf + BUF_W'(1);
        frame_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 16'd1;
        frame_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_buf][w_addr] <= din;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dout <= '0;
    end else if (frame_valid && ({1'b0, r_addr} < PIX_LIM)) begin
      dout <= mem[rd_buf][r_addr];
    end else begin
      dout <= '0;
    end
  end

endmodule

// File: tb/tb_camera_frame_buffer.sv
// Bench for camera_frame_buffer (8x4 main instance, 5x4 instance for out-of-range reads).
module tb_camera_frame_buffer;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int PIX = W * H;

  logic       clk;
  logic       n_rst;
  logic       w_req, cont, abort, din_valid;
  logic [7:0] din;
  logic [4:0] r_addr;
  logic [7:0] dout;
  logic [2:0] hcount;
  logic [1:0] vcount;
  logic       busy, frame_valid, frame_done;
  logic [15:0] frame_cnt;
  logic [1:0] dbg_state;

  logic       s_w_req, s_din_valid;
  logic [7:0] s_din;
  logic [4:0] s_r_addr;
  logic [7:0] s_dout;
  logic [2:0] s_hcount;
  logic [1:0] s_vcount;
  logic       s_busy, s_frame_valid, s_frame_done;
  logic [15:0] s_frame_cnt;
  logic [1:0] s_dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model: frame-level view of the block
  logic [7:0] m_pix[$];
  logic [7:0] m_frame[$];
  logic [7:0] m_pub[$];
  bit         m_cap, m_commit, m_valid;
  int         m_cnt;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab[5];
  rd_vec_t s_tab[6];

  camera_frame_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .NUM_BUFS(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .w_req(w_req), .cont(cont), .abort(abort),
    .din(din), .din_valid(din_valid), .r_addr(r_addr), .dout(dout),
    .hcount(hcount), .vcount(vcount), .busy(busy), .frame_valid(frame_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  camera_frame_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .DATA_WIDTH(8), .NUM_BUFS(2)) u_small (
    .clk(clk), .n_rst(n_rst), .w_req(s_w_req), .cont(1'b0), .abort(1'b0),
    .din(s_din), .din_valid(s_din_valid), .r_addr(s_r_addr), .dout(s_dout),
    .hcount(s_hcount), .vcount(s_vcount), .busy(s_busy), .frame_valid(s_frame_valid),
    .frame_done(s_frame_done), .frame_cnt(s_frame_cnt), .dbg_state(s_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pix.delete();
    m_frame.delete();
    m_pub.delete();
    m_cap    = 1'b0;
    m_commit = 1'b0;
    m_valid  = 1'b0;
    m_cnt    = 0;
  endtask

  // One clock: advance the model on the current inputs, clock, compare.
  task automatic tick();
    logic [7:0]  exp_dout;
    bit          exp_done;
    logic [1:0]  exp_state;
    exp_dout = (m_valid && int'(r_addr) < PIX) ? m_pub[r_addr] : 8'h00;
    exp_done = m_commit;
    if (m_commit) begin
      m_pub    = m_frame;
      m_valid  = 1'b1;
      m_cnt    = (m_cnt + 1) % 65536;
      m_commit = 1'b0;
      m_cap    = w_req || cont;
    end else if (m_cap) begin
      if (abort) begin
        m_pix.delete();
        m_cap = 1'b0;
      end else if (din_valid) begin
        m_pix.push_back(din);
        if (m_pix.size() == PIX) begin
          m_frame = m_pix;
          m_pix.delete();
          m_cap    = 1'b0;
          m_commit = 1'b1;
        end
      end
    end else begin
      m_cap = w_req || cont;
    end
    @(posedge clk);
    #1;
    exp_state = m_commit ? 2'd2 : (m_cap ? 2'd1 : 2'd0);
    chk("dout", dout, exp_dout);
    chk("hcount", hcount, m_pix.size() % W);
    chk("vcount", vcount, m_pix.size() / W);
    chk("busy", busy, m_cap || m_commit);
    chk("frame_done", frame_done, exp_done);
    chk("frame_valid", frame_valid, m_valid);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("dbg_state", dbg_state, exp_state);
  endtask

  // Entered and left at posedge+1; reset asserted mid-cycle.
  task automatic do_reset();
    w_req = 0; cont = 0; abort = 0; din_valid = 0; din = 0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_small_valid", s_frame_valid, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic start_frame();
    w_req = 1'b1;
    tick();
    w_req = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      din = 8'(base + i);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic run_rd_tab(input string tag);
    for (int i = 0; i < 5; i++) begin
      r_addr = rd_tab[i].addr;
      tick();
      chk(tag, dout, rd_tab[i].exp);
    end
  endtask

  initial begin
    rd_tab[0] = '{5'd5,  8'h05};
    rd_tab[1] = '{5'd31, 8'h1F};
    rd_tab[2] = '{5'd0,  8'h00};
    rd_tab[3] = '{5'd8,  8'h08};
    rd_tab[4] = '{5'd20, 8'h14};
    s_tab[0]  = '{5'd19, 8'h93};
    s_tab[1]  = '{5'd0,  8'h80};
    s_tab[2]  = '{5'd5,  8'h85};
    s_tab[3]  = '{5'd20, 8'h00};
    s_tab[4]  = '{5'd25, 8'h00};
    s_tab[5]  = '{5'd31, 8'h00};

    n_rst = 1'b1;
    w_req = 0; cont = 0; abort = 0; din_valid = 0; din = 0; r_addr = 0;
    s_w_req = 0; s_din_valid = 0; s_din = 0; s_r_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset, then reads before any frame
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r_addr = 5'($urandom);
      tick();
      chk("pre_frame_dout", dout, 0);
    end

    // single frame
    start_frame();
    send_frame(PIX, 0);
    tick();
    chk("single_done", frame_done, 1);
    tick();
    chk("single_done_fall", frame_done, 0);
    chk("single_cnt", frame_cnt, 1);
    chk("single_busy", busy, 0);
    run_rd_tab("single_read");

    // gapped stream, same image
    start_frame();
    for (int i = 0; i < PIX; i++) begin
      din = 8'(i);
      din_valid = 1'b1;
      tick();
      if (i == 7) begin
        chk("gap_hwrap", hcount, 0);
        chk("gap_vinc", vcount, 1);
      end
      din = 8'hEE;
      din_valid = 1'b0;
      tick();
      if (i == 7) chk("gap_hold", {vcount, hcount}, {2'd1, 3'd0});
    end
    tick();
    tick();
    chk("gap_cnt", frame_cnt, 2);
    run_rd_tab("gap_read");

    // ping-pong in continuous mode
    do_reset();
    cont = 1'b1;
    tick();
    send_frame(PIX, 0);
    din = 8'hAA;
    din_valid = 1'b1;
    tick();
    for (int i = 0; i < PIX; i++) begin
      din = 8'(8'h40 + i);
      din_valid = 1'b1;
      r_addr = 5'(i);
      tick();
      chk("pp_old_frame", dout, i);
    end
    din_valid = 1'b0;
    cont = 1'b0;
    r_addr = 5'd3;
    tick();
    chk("pp_n1_old", dout, 8'h03);
    tick();
    chk("pp_n2_new", dout, 8'h43);
    chk("pp_cnt", frame_cnt, 2);

    // abort mid-frame, then a clean frame
    do_reset();
    start_frame();
    send_frame(PIX, 8'h10);
    tick();
    tick();
    start_frame();
    send_frame(10, 8'h30);
    din = 8'h3A;
    din_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_counts", {vcount, hcount}, 0);
    chk("abort_cnt", frame_cnt, 1);
    r_addr = 5'd12;
    tick();
    chk("abort_read_old", dout, 8'h1C);
    start_frame();
    send_frame(PIX, 8'h20);
    tick();
    tick();
    chk("abort_next_cnt", frame_cnt, 2);
    tick();
    chk("abort_next_read", dout, 8'h2C);

    // abort together with the last pixel
    start_frame();
    send_frame(PIX - 1, 8'h50);
    din = 8'h6F;
    din_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    tick();
    chk("abort_last_done", frame_done, 0);
    chk("abort_last_cnt", frame_cnt, 2);
    r_addr = 5'd31;
    tick();
    chk("abort_last_read", dout, 8'h3F);

    // reset during capture
    start_frame();
    send_frame(5, 0);
    do_reset();
    tick();
    chk("rst_cap_busy", busy, 0);
    chk("rst_cap_valid", frame_valid, 0);

    // non-power-of-two instance: out-of-range reads
    s_w_req = 1'b1;
    tick();
    s_w_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_din = 8'(8'h80 + i);
      s_din_valid = 1'b1;
      tick();
      if (i == 4) chk("small_wrap", {s_vcount, s_hcount}, {2'd1, 3'd0});
    end
    s_din_valid = 1'b0;
    chk("small_commit_state", s_dbg_state, 2);
    chk("small_commit_busy", s_busy, 1);
    tick();
    chk("small_done", s_frame_done, 1);
    chk("small_valid", s_frame_valid, 1);
    tick();
    chk("small_cnt", s_frame_cnt, 1);
    chk("small_idle", s_dbg_state, 0);
    for (int i = 0; i < 6; i++) begin
      s_r_addr = s_tab[i].addr;
      tick();
      chk("small_read", s_dout, s_tab[i].exp);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) cont = ($urandom_range(0, 1) == 1);
      w_req     = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      r_addr    = 5'($urandom);
      tick();
    end
    chk("random_frames_seen", (m_cnt > 5), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
